// File: rtl/udp_arb_pkg.sv
// -----------------------------------------------------------------------------
// udp_arb_pkg
// Shared types and default sizing for the UDP detector FIFO drain arbiter.
//   arb_state_t        : drain FSM states (IDLE -> READ -> WAIT -> HOLD)
//   ARB_*_DEF          : default NUM_CH / DATA_W / MAX_BURST for udp_fifo_arbiter
// No ports (package).
// -----------------------------------------------------------------------------
package udp_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_READ,
    ARB_WAIT,
    ARB_HOLD
  } arb_state_t;

  localparam int ARB_NUM_CH_DEF    = 4;
  localparam int ARB_DATA_W_DEF    = 32;
  localparam int ARB_MAX_BURST_DEF = 16;

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority picker: returns the first requesting
// channel at or after ptr, wrapping NUM_CH-1 -> 0.
// Ports:
//   req      in  [NUM_CH]  per-channel request (FIFO not empty)
//   ptr      in  [ID_W]    highest-priority channel this round
//   grant    out [ID_W]    picked channel (0 when no request)
//   any_req  out 1         at least one request present
// -----------------------------------------------------------------------------
module rr_pick
  import udp_arb_pkg::*;
#(
  parameter  int NUM_CH = ARB_NUM_CH_DEF,
  localparam int ID_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [ID_W-1:0]   ptr,
  output logic [ID_W-1:0]   grant,
  output logic              any_req
);

  // One extra bit so ptr + offset can be folded back below NUM_CH.
  logic [ID_W:0] cand;

  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    cand    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = {1'b0, ptr} + (ID_W+1)'(i);
      if (cand >= (ID_W+1)'(NUM_CH)) begin
        cand = cand - (ID_W+1)'(NUM_CH);
      end
      if (!any_req && req[cand[ID_W-1:0]]) begin
        grant   = cand[ID_W-1:0];
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/udp_fifo_arbiter.sv
// -----------------------------------------------------------------------------
// udp_fifo_arbiter
// Round-robin drain controller for NUM_CH UDP-detector word FIFOs feeding one
// AXI-stream sink. Each word takes READ (strobe) -> WAIT (capture) -> HOLD
// (handshake); a grant drains up to MAX_BURST words before rotating.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   enable            0: no new grants/words; word in flight still completes
//   ch_empty[NUM_CH]  per-FIFO empty flags
//   ch_data           per-FIFO read data, ch i at [i*DATA_W +: DATA_W]
//   ch_rd_en[NUM_CH]  one-hot read strobe, one cycle per word
//   m_tdata/m_tid/m_tlast/m_tvalid/m_tready  AXI-stream master
// Optional (macro UDP_ARB_STATS_EN):
//   stat_clr          sync clear of all counters, wins over increment
//   stat_words        per-channel handshaked word counts, 32 bits each, wrap
//   stat_stall        HOLD cycles with m_tready=0, saturating
// -----------------------------------------------------------------------------
module udp_fifo_arbiter
  import udp_arb_pkg::*;
#(
  parameter  int NUM_CH    = ARB_NUM_CH_DEF,
  parameter  int DATA_W    = ARB_DATA_W_DEF,
  parameter  int MAX_BURST = ARB_MAX_BURST_DEF,
  localparam int ID_W      = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [NUM_CH-1:0]        ch_empty,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [NUM_CH-1:0]        ch_rd_en,
  output logic [DATA_W-1:0]        m_tdata,
  output logic [ID_W-1:0]          m_tid,
  output logic                     m_tlast,
  output logic                     m_tvalid,
  input  logic                     m_tready
`ifdef UDP_ARB_STATS_EN
  ,
  input  logic                     stat_clr,
  output logic [NUM_CH*32-1:0]     stat_words,
  output logic [31:0]              stat_stall
`endif
);

  arb_state_t        state;
  logic [ID_W-1:0]   grant;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   pick;
  logic              pick_vld;
  logic [NUM_CH-1:0] req;
  logic [7:0]        burst_cnt;

  function automatic logic [ID_W-1:0] next_ch(input logic [ID_W-1:0] g);
    return (g == ID_W'(NUM_CH-1)) ? '0 : g + 1'b1;
  endfunction

  assign req = ~ch_empty;

  rr_pick #(.NUM_CH(NUM_CH)) u_rr_pick (
    .req     (req),
    .ptr     (rr_ptr),
    .grant   (pick),
    .any_req (pick_vld)
  );

  // The strobe is decoded from registered state but gated by the live empty
  // flag, so a FIFO that drained since the grant is never read.
  assign ch_rd_en = (state == ARB_READ && !ch_empty[grant]) ?
                    (NUM_CH'(1) << grant) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB_IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      m_tdata   <= '0;
      m_tid     <= '0;
      m_tlast   <= 1'b0;
      m_tvalid  <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (enable && pick_vld) begin
            grant <= pick;
            state <= ARB_READ;
          end
        end
        ARB_READ: begin
          if (ch_empty[grant]) begin
            // Nothing left to read: close the grant without a strobe.
            rr_ptr    <= next_ch(grant);
            burst_cnt <= '0;
            state     <= ARB_IDLE;
          end else begin
            burst_cnt <= burst_cnt + 8'd1;
            state     <= ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          m_tdata  <= ch_data[grant*DATA_W +: DATA_W];
          m_tid    <= grant;
          m_tvalid <= 1'b1;
          // Burst limit, FIFO drained by this read, or enable dropped.
          m_tlast  <= (burst_cnt == 8'(MAX_BURST)) || ch_empty[grant] || !enable;
          state    <= ARB_HOLD;
        end
        ARB_HOLD: begin
          if (m_tready) begin
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            if (!m_tlast && enable) begin
              state <= ARB_READ;
            end else begin
              rr_ptr    <= next_ch(grant);
              burst_cnt <= '0;
              state     <= ARB_IDLE;
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

`ifdef UDP_ARB_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_words <= '0;
      stat_stall <= '0;
    end else if (stat_clr) begin
      stat_words <= '0;
      stat_stall <= '0;
    end else if (state == ARB_HOLD) begin
      if (m_tready) begin
        stat_words[m_tid*32 +: 32] <= stat_words[m_tid*32 +: 32] + 32'd1;
      end else begin
        stat_stall <= sat_inc(stat_stall);
      end
    end
  end
`endif

endmodule
